// File: rtl/vga_scan_timer_if.sv
// Scan-timer bus: advance enable in, pixel position / sync / strobes out.
interface vga_scan_timer_if #(
  parameter int unsigned H_W = 10,
  parameter int unsigned V_W = 10
);
  logic           en;
  logic           pix_tick;
  logic [H_W-1:0] pos_x;
  logic [V_W-1:0] pos_y;
  logic           hsync;
  logic           vsync;
  logic           video_on;
  logic           line_start;
  logic           frame_start;

  // Timer side: consumes enable, produces scan state.
  modport master (
    input  en,
    output pix_tick, pos_x, pos_y, hsync, vsync, video_on, line_start, frame_start
  );

  // Renderer / controller side.
  modport slave (
    output en,
    input  pix_tick, pos_x, pos_y, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_scan_timer.sv
// VGA scan generator: pixel prescaler plus horizontal/vertical counters with registered
// sync, active-video and line/frame strobes. All decoded outputs are taken from the
// next-state counter values so they change on the same edge as pos_x/pos_y.
module vga_scan_timer #(
  parameter int unsigned CLK_PER_PIX = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned H_W         = 10,
  parameter int unsigned V_W         = 10
) (
  input logic              clk,
  input logic              rst_n,
  vga_scan_timer_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PRE_W   = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_PIX - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_VIS    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]   V_VIS    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [PRE_W-1:0] r_pre;
  logic [H_W-1:0]   r_pos_x;
  logic [V_W-1:0]   r_pos_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_line_start;
  logic             r_frame_start;

  logic [PRE_W-1:0] w_pre_nxt;
  logic [H_W-1:0]   w_pos_x_nxt;
  logic [V_W-1:0]   w_pos_y_nxt;
  logic             w_pre_last;
  logic             w_tick;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_video_on_nxt;
  logic             w_line_start_nxt;
  logic             w_frame_start_nxt;

  assign w_pre_last = (r_pre == PRE_LAST);
  assign w_tick     = bus.en && w_pre_last;
  assign w_x_last   = (r_pos_x == H_LAST);
  assign w_y_last   = (r_pos_y == V_LAST);

  // Next-state counters and decode of the position they will hold after this edge.
  always_comb begin
    w_pre_nxt   = w_pre_last ? '0 : r_pre + PRE_W'(1);
    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    if (w_tick) begin
      if (w_x_last) begin
        w_pos_x_nxt = '0;
        w_pos_y_nxt = w_y_last ? '0 : r_pos_y + V_W'(1);
      end else begin
        w_pos_x_nxt = r_pos_x + H_W'(1);
      end
    end
    w_hsync_nxt       = ((w_pos_x_nxt >= HS_BEG) && (w_pos_x_nxt < HS_END)) ? SYNC_POL
                                                                            : ~SYNC_POL;
    w_vsync_nxt       = ((w_pos_y_nxt >= VS_BEG) && (w_pos_y_nxt < VS_END)) ? SYNC_POL
                                                                            : ~SYNC_POL;
    w_video_on_nxt    = (w_pos_x_nxt < H_VIS) && (w_pos_y_nxt < V_VIS);
    // Strobes are gated by w_tick, so they drop to 0 in any disabled clock.
    w_line_start_nxt  = w_tick && w_x_last;
    w_frame_start_nxt = w_line_start_nxt && w_y_last;
  end

  // Scan state: advances only while enabled; strobes reload every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre         <= '0;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (bus.en) begin
        r_pre      <= w_pre_nxt;
        r_pos_x    <= w_pos_x_nxt;
        r_pos_y    <= w_pos_y_nxt;
        r_hsync    <= w_hsync_nxt;
        r_vsync    <= w_vsync_nxt;
        r_video_on <= w_video_on_nxt;
      end
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign bus.pix_tick    = w_tick;
  assign bus.pos_x       = r_pos_x;
  assign bus.pos_y       = r_pos_y;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: three configurations (defaults, CPP=2 small frame, CPP=1 tiny
// frame with active-high sync) checked every clock against a closed-form scan model, plus
// a hand-written vector table and reset / enable corner sequences.
module tb_vga_scan_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  vga_scan_timer_if #(.H_W(10), .V_W(10)) if_d ();
  vga_scan_timer_if #(.H_W(4),  .V_W(4))  if_a ();
  vga_scan_timer_if #(.H_W(4),  .V_W(3))  if_b ();

  vga_scan_timer u_d (.clk(clk), .rst_n(rst_d), .bus(if_d));

  vga_scan_timer #(
    .CLK_PER_PIX(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .H_W(4), .V_W(4)
  ) u_a (.clk(clk), .rst_n(rst_a), .bus(if_a));

  vga_scan_timer #(
    .CLK_PER_PIX(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .H_W(4), .V_W(3)
  ) u_b (.clk(clk), .rst_n(rst_b), .bus(if_b));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int tick; int x; int y; int hs; int vs; int vo; int ls; int fs;
  } exp_t;

  // Expected outputs after n enabled clocks since reset: n/cpp pixels have elapsed.
  function automatic exp_t model(int n, int last_en, int en_now, int cpp,
                                 int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp, int pol);
    exp_t e;
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int p  = n / cpp;
    e.x    = p % ht;
    e.y    = (p / ht) % vt;
    e.tick = (en_now != 0 && (n % cpp) == cpp - 1) ? 1 : 0;
    if (n == 0) begin
      e.hs = 1 - pol; e.vs = 1 - pol; e.vo = 0;
    end else begin
      e.hs = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? pol : 1 - pol;
      e.vs = (e.y >= va + vfp && e.y < va + vfp + vsw) ? pol : 1 - pol;
      e.vo = (e.x < ha && e.y < va) ? 1 : 0;
    end
    e.ls = (last_en != 0 && n > 0 && (n % cpp) == 0 && e.x == 0) ? 1 : 0;
    e.fs = (e.ls != 0 && e.y == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(string tag, exp_t e, logic tick, logic [31:0] x, logic [31:0] y,
                         logic hs, logic vs, logic vo, logic ls, logic fs);
    chk({tag, ".pix_tick"},    32'(tick), e.tick);
    chk({tag, ".pos_x"},       x,         e.x);
    chk({tag, ".pos_y"},       y,         e.y);
    chk({tag, ".hsync"},       32'(hs),   e.hs);
    chk({tag, ".vsync"},       32'(vs),   e.vs);
    chk({tag, ".video_on"},    32'(vo),   e.vo);
    chk({tag, ".line_start"},  32'(ls),   e.ls);
    chk({tag, ".frame_start"}, 32'(fs),   e.fs);
  endtask

  // Model state: enabled clocks since reset and whether the last clock was enabled.
  int n_d = 0, n_a = 0, n_b = 0;
  int le_d = 0, le_a = 0, le_b = 0;

  always @(posedge clk or negedge rst_d)
    if (!rst_d) begin n_d <= 0; le_d <= 0; end
    else begin le_d <= int'(if_d.en); if (if_d.en) n_d <= n_d + 1; end
  always @(posedge clk or negedge rst_a)
    if (!rst_a) begin n_a <= 0; le_a <= 0; end
    else begin le_a <= int'(if_a.en); if (if_a.en) n_a <= n_a + 1; end
  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin n_b <= 0; le_b <= 0; end
    else begin le_b <= int'(if_b.en); if (if_b.en) n_b <= n_b + 1; end

  bit run_chk = 1'b0;

  // Every-clock comparison of all three instances, sampled on the falling edge.
  always @(negedge clk) begin
    if (run_chk) begin
      cmp_all("d", model(n_d, le_d, int'(if_d.en), 2, 640, 16, 96, 48, 480, 10, 2, 33, 0),
              if_d.pix_tick, 32'(if_d.pos_x), 32'(if_d.pos_y), if_d.hsync, if_d.vsync,
              if_d.video_on, if_d.line_start, if_d.frame_start);
      cmp_all("a", model(n_a, le_a, int'(if_a.en), 2, 8, 2, 3, 2, 5, 1, 2, 1, 0),
              if_a.pix_tick, 32'(if_a.pos_x), 32'(if_a.pos_y), if_a.hsync, if_a.vsync,
              if_a.video_on, if_a.line_start, if_a.frame_start);
      cmp_all("b", model(n_b, le_b, int'(if_b.en), 1, 6, 1, 2, 1, 3, 1, 1, 1, 1),
              if_b.pix_tick, 32'(if_b.pos_x), 32'(if_b.pos_y), if_b.hsync, if_b.vsync,
              if_b.video_on, if_b.line_start, if_b.frame_start);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n; int tick; int x; int y; int hs; int vs; int vo; int ls; int fs;
  } vec_t;

  vec_t tab[10];

  initial begin
    int last_fs;
    int nfs;
    int last_ls;
    int nls;
    int hs_low;
    int max_x;
    bit seen;

    // Instance b: 10x6 frame, CPP=1, active-high sync (hsync at x 7..8, vsync at y 4).
    tab[0] = '{n:1,   tick:1, x:1, y:0, hs:0, vs:0, vo:1, ls:0, fs:0};
    tab[1] = '{n:7,   tick:1, x:7, y:0, hs:1, vs:0, vo:0, ls:0, fs:0};
    tab[2] = '{n:9,   tick:1, x:9, y:0, hs:0, vs:0, vo:0, ls:0, fs:0};
    tab[3] = '{n:10,  tick:1, x:0, y:1, hs:0, vs:0, vo:1, ls:1, fs:0};
    tab[4] = '{n:40,  tick:1, x:0, y:4, hs:0, vs:1, vo:0, ls:1, fs:0};
    tab[5] = '{n:47,  tick:1, x:7, y:4, hs:1, vs:1, vo:0, ls:0, fs:0};
    tab[6] = '{n:59,  tick:1, x:9, y:5, hs:0, vs:0, vo:0, ls:0, fs:0};
    tab[7] = '{n:60,  tick:1, x:0, y:0, hs:0, vs:0, vo:1, ls:1, fs:1};
    tab[8] = '{n:61,  tick:1, x:1, y:0, hs:0, vs:0, vo:1, ls:0, fs:0};
    tab[9] = '{n:120, tick:1, x:0, y:0, hs:0, vs:0, vo:1, ls:1, fs:1};

    if_d.en = 1'b0; if_a.en = 1'b0; if_b.en = 1'b0;
    run_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a.reset_hsync", 32'(if_a.hsync), 1);
    chk("b.reset_hsync", 32'(if_b.hsync), 0);
    chk("d.reset_video_on", 32'(if_d.video_on), 0);
    rst_d = 1'b1; rst_a = 1'b1; rst_b = 1'b1;

    // Phase 1: vector table on instance b.
    @(posedge clk); #1;
    if_b.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do begin @(posedge clk); #1; end while (n_b < tab[i].n);
      chk($sformatf("tab%0d.n", i),    32'(n_b), tab[i].n);
      chk($sformatf("tab%0d.tick", i), 32'(if_b.pix_tick), tab[i].tick);
      chk($sformatf("tab%0d.x", i),    32'(if_b.pos_x), tab[i].x);
      chk($sformatf("tab%0d.y", i),    32'(if_b.pos_y), tab[i].y);
      chk($sformatf("tab%0d.hs", i),   32'(if_b.hsync), tab[i].hs);
      chk($sformatf("tab%0d.vs", i),   32'(if_b.vsync), tab[i].vs);
      chk($sformatf("tab%0d.vo", i),   32'(if_b.video_on), tab[i].vo);
      chk($sformatf("tab%0d.ls", i),   32'(if_b.line_start), tab[i].ls);
      chk($sformatf("tab%0d.fs", i),   32'(if_b.frame_start), tab[i].fs);
    end
    if_b.en = 1'b0;

    // Phase 2: instance a with random enable; frame_start every 270 enabled clocks.
    last_fs = -1; nfs = 0;
    for (int k = 0; k < 2400; k++) begin
      @(posedge clk); #1;
      if (if_a.frame_start) begin
        if (last_fs < 0) chk("a.first_fs_n", 32'(n_a), 270);
        else chk("a.fs_interval", 32'(n_a - last_fs), 270);
        last_fs = n_a;
        nfs++;
      end
      if_a.en = 1'($urandom_range(0, 1));
    end
    chk("a.fs_count_ge2", 32'(nfs >= 2), 1);

    // Phase 3: asynchronous reset of instance a inside hsync+vsync (x=11, y=6).
    if_a.en = 1'b1;
    do begin @(posedge clk); #1; end while (((n_a / 2) % 135) != 101);
    chk("a.pre_rst_x", 32'(if_a.pos_x), 11);
    chk("a.pre_rst_y", 32'(if_a.pos_y), 6);
    chk("a.pre_rst_hs", 32'(if_a.hsync), 0);
    chk("a.pre_rst_vs", 32'(if_a.vsync), 0);
    #2 rst_a = 1'b0;
    #1;
    chk("a.rst_x", 32'(if_a.pos_x), 0);
    chk("a.rst_y", 32'(if_a.pos_y), 0);
    chk("a.rst_hs", 32'(if_a.hsync), 1);
    chk("a.rst_vs", 32'(if_a.vsync), 1);
    chk("a.rst_vo", 32'(if_a.video_on), 0);
    chk("a.rst_ls", 32'(if_a.line_start), 0);
    chk("a.rst_fs", 32'(if_a.frame_start), 0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 700 && !seen; k++) begin
      @(posedge clk); #1;
      if (if_a.frame_start) seen = 1'b1;
    end
    chk("a.restart_fs_seen", 32'(seen), 1);
    chk("a.restart_fs_n", 32'(n_a), 270);
    if_a.en = 1'b0;

    // Phase 4: default timing over two full lines.
    if_d.en = 1'b1;
    last_ls = -1; nls = 0; hs_low = 0; max_x = 0;
    for (int k = 0; k < 3220; k++) begin
      @(posedge clk); #1;
      if (n_d >= 1 && n_d <= 1600 && if_d.hsync == 1'b0) hs_low++;
      if (int'(if_d.pos_x) > max_x) max_x = int'(if_d.pos_x);
      if (if_d.line_start) begin
        if (last_ls < 0) chk("d.first_ls_n", 32'(n_d), 1600);
        else chk("d.ls_interval", 32'(n_d - last_ls), 1600);
        last_ls = n_d;
        nls++;
      end
    end
    chk("d.hsync_low_clocks", 32'(hs_low), 192);
    chk("d.max_pos_x", 32'(max_x), 799);
    chk("d.ls_count", 32'(nls), 2);

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_timer.md
# vga_scan_timer

Parametrised VGA scan generator that succeeds the combinational vertical-position divider. It no longer divides a free-running 20-bit frame counter by the line length. Instead it keeps its own pixel prescaler plus horizontal and vertical counters, and drives horizontal/vertical pixel position, sync pulses, active-video flag and line/frame strobes. It sits between the system clock and the pixel/character renderers. The default parameters reproduce the existing 640x480@60 timing at 2 clocks per pixel: 1600 clocks per line and 840000 clocks per frame.

## Interface
- CLK_PER_PIX, 2, system clocks per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- H_W, 10, width of pos_x (must hold H_TOTAL-1)
- V_W, 10, width of pos_y (must hold V_TOTAL-1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance enable; low freezes all state
- pix_tick  out  1  high in the clock in which counters advance
- pos_x  out  H_W  horizontal counter, 0..H_TOTAL-1
- pos_y  out  V_W  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  pos_x < H_ACTIVE and pos_y < V_ACTIVE
- line_start  out  1  one-clock pulse, pos_x just wrapped to 0
- frame_start  out  1  one-clock pulse, pos_x and pos_y just wrapped to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Prescaler `pre` counts 0..CLK_PER_PIX-1 on every clock with en=1, then wraps to 0.
- pix_tick = en && pre==CLK_PER_PIX-1. This is combinational from registers. With CLK_PER_PIX=1, pix_tick = en.
- On a clock edge where pix_tick=1:
  - pos_x increments.
  - At H_TOTAL-1, pos_x wraps to 0 and pos_y increments.
  - At V_TOTAL-1 together with pos_x wrap, pos_y wraps to 0.
- hsync is asserted (=SYNC_POL) for H_ACTIVE+H_FP <= pos_x < H_ACTIVE+H_FP+H_SYNC (default 656..751), and equals ~SYNC_POL otherwise.
- vsync is asserted for V_ACTIVE+V_FP <= pos_y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- hsync, vsync and video_on are registered. Each is computed from the next-state counter values, so all outputs change on the same edge as pos_x/pos_y. No decode glitches are allowed.
- line_start is registered, high for exactly the one clock following the edge where pos_x wrapped H_TOTAL-1 -> 0.
- frame_start is the same, but only when pos_y also wrapped V_TOTAL-1 -> 0. On that edge line_start is high as well.
- en=0: pre, pos_x, pos_y, hsync, vsync and video_on hold their values. line_start and frame_start go 0.
- Arithmetic: counters are unsigned. Compares use full H_W/V_W width. No state beyond H_TOTAL-1 / V_TOTAL-1 is reachable.

## Timing
- Reset (rst_n low, asynchronous):
  - pre=0, pos_x=0, pos_y=0.
  - hsync=vsync=~SYNC_POL.
  - video_on=0, line_start=0, frame_start=0.
- First rising edge after release with en=1: video_on becomes 1 (decode of 0,0). Counters stay at 0 until the first pix_tick.
- No frame_start or line_start pulse is generated by reset release. The first frame_start comes after one full frame.
- Latency: an output change follows the pix_tick edge by 0 cycles, with all outputs valid in the cycle after that edge.
- Period: pos_x advances every CLK_PER_PIX enabled clocks. Line = H_TOTAL*CLK_PER_PIX enabled clocks; frame = H_TOTAL*V_TOTAL*CLK_PER_PIX.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). Restart behaves as a fresh start.
- en dropped in the same cycle as a would-be wrap: the wrap is deferred until the next enabled pix_tick. No pulse is lost or duplicated.

## Test plan
- Defaults, en=1 after reset: pos_x reaches 799 then wraps to 0. line_start pulses every 1600 clocks. frame_start pulses every 840000 clocks, first at clock 840000 after release.
- Defaults: hsync low exactly while pos_x is 656..751 (192 clocks per line). vsync low exactly while pos_y is 490..491 (3200 clocks). video_on high for 640*480*2 clocks per frame.
- CLK_PER_PIX=1, H/V totals 10/6, SYNC_POL=1: hsync high for the configured range, full frame = 60 clocks. pix_tick is constant 1.
- Toggle en randomly at 50%: counters advance only on en clocks. The frame_start interval equals 840000 enabled clocks. No output changes while en=0.
- Assert rst_n low at pos_x=700, pos_y=490: immediately pos=0,0, hsync=vsync=1 (SYNC_POL=0), video_on=0. After release, timing is identical to cold start.
